sprite_anim_ctrl: RTL and testbench
===================================

SPRITE_ANIM_CTRL -- requirements
Module: sprite_anim_ctrl

Interface
REQ-001 SHALL have parameter SPR_W, default 60: sprite width in pixels, equal to the column stride between frames in the sprite ROM.
REQ-002 SHALL have parameter SPR_H, default 80: sprite height in pixels.
REQ-003 SHALL have parameter NUM_FRAMES, default 4: walk frames per facing direction.
REQ-004 SHALL have parameter FRAME_DIV, default 8: frame ticks per animation step.
REQ-005 SHALL have parameter STEP, default 2: pixels moved per frame tick per axis.
REQ-006 SHALL have parameters SCREEN_W = 640, SCREEN_H = 480, START_X = 290, START_Y = 200.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have ports hc and vc, input, 11 bits each: current raster pixel coordinates.
REQ-010 SHALL have ports btn_l, btn_r, btn_u and btn_d, input, 1 bit each: movement requests, level-sensitive, already debounced.
REQ-011 SHALL have port pause, input, 1 bit: freeze request, level-sensitive.
REQ-012 SHALL have ports x0, y0, x1 and y1, output, 11 bits each, registered: sprite placement window for the sprite renderer.
REQ-013 SHALL have port sprite_num, output, 10 bits, registered: ROM column offset of the current frame.
REQ-014 SHALL have port state_o, output, 2 bits: current state, encoded IDLE = 0, WALK = 1, PAUSE = 2.

Function
REQ-015 SHALL generate an internal one-cycle frame tick on the first clk in which (vc == SCREEN_H && hc == 0) becomes true.
REQ-016 SHALL raise the frame tick exactly once per raster frame, even if hc and vc are held for several clks; detection is by rising edge of the registered condition.
REQ-017 SHALL evaluate state transitions and position updates only on frame tick cycles; on all other cycles the outputs and state SHALL hold.
REQ-018 SHALL give pause the highest priority: any state goes to PAUSE when pause = 1.
REQ-019 SHALL, in PAUSE with pause = 0, go to WALK if any button is pressed, else to IDLE.
REQ-020 SHALL hold position, frame index and divider in PAUSE.
REQ-021 SHALL move from IDLE to WALK when any button is pressed, and from WALK to IDLE when none is pressed.
REQ-022 SHALL cancel an axis when both buttons of that axis are pressed (btn_l & btn_r cancels X; btn_u & btn_d cancels Y).
REQ-023 SHALL treat all four buttons pressed as no button pressed.
REQ-024 SHALL, in WALK on each tick: x0 -= STEP on left, x0 += STEP on right, y0 -= STEP on up, y0 += STEP on down.
REQ-025 SHALL compute x0 and y0 with signed 12-bit intermediates.
REQ-026 SHALL clamp x0 to [0, SCREEN_W-SPR_W] and y0 to [0, SCREEN_H-SPR_H]; no wrap-around.
REQ-027 SHALL, in WALK on each tick, increment the divider; when the divider reaches FRAME_DIV-1 it SHALL reset to 0 and the frame index SHALL advance, wrapping from NUM_FRAMES-1 to 0.
REQ-028 SHALL set the frame index and divider to 0 on entry to IDLE.
REQ-029 SHALL set facing = left on a tick with left-only X input and facing = right on right-only X input; otherwise facing holds.
REQ-030 SHALL drive sprite_num = frame*SPR_W + (facing_left ? NUM_FRAMES*SPR_W : 0), registered.
REQ-031 SHALL drive x1 = x0 + SPR_W and y1 = y0 + SPR_H, updated in the same clk as x0 and y0.
REQ-032 SHALL make all outputs reflect a tick's update on the clk after the tick (latency 1).

Reset
REQ-033 SHALL, while rst = 1 at a clk edge, force x0 = START_X, y0 = START_Y, x1 = START_X+SPR_W, y1 = START_Y+SPR_H, sprite_num = 0, state IDLE, facing right, divider 0, frame 0, and tick-detect register 0.
REQ-034 SHALL let reset take priority over a coincident frame tick or pause.
REQ-035 SHALL let reset asserted mid-WALK discard all motion and animation state.

Verification
REQ-036 SHALL cover reset: rst for 2 clks -> x0 = 290, y0 = 200, x1 = 350, y1 = 280, sprite_num = 0, state_o = 0.
REQ-037 SHALL cover hold and single tick: hold btn_r, 3 frame ticks (hc/vc each held 4 clks) -> x0 = 296, exactly 3 updates, state_o = 1.
REQ-038 SHALL cover animation: hold btn_r for 8 ticks -> sprite_num = 60; after 32 ticks -> sprite_num = 0 (wrap).
REQ-039 SHALL cover facing: hold btn_l for 8 ticks -> sprite_num = 240 + 60 = 300, and x0 = 274.
REQ-040 SHALL cover clamping: start x0 = 0, hold btn_l and btn_u from y0 = 1 -> x0 stays 0, y0 = 0 after 1 tick; btn_l+btn_r -> x0 unchanged.
REQ-041 SHALL cover pause: pause = 1 during WALK for 5 ticks -> outputs frozen, state_o = 2; release with btn_d held -> state_o = 1, y0 += 2 per tick.

Source files
------------

// File: rtl/sprite_anim_ctrl.sv
// rtl/sprite_anim_ctrl.sv - walking sprite position, facing and frame animation controller
module sprite_anim_ctrl #(
  parameter int SPR_W      = 60,
  parameter int SPR_H      = 80,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 8,
  parameter int STEP       = 2,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int START_X    = 290,
  parameter int START_Y    = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        pause,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic [9:0]  sprite_num,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int FB = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DB = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FB-1:0] FRAME_LAST = FB'(NUM_FRAMES - 1);
  localparam logic [DB-1:0] DIV_LAST   = DB'(FRAME_DIV - 1);
  localparam logic signed [11:0] C_STEP = 12'(STEP);
  localparam logic signed [11:0] C_XMAX = 12'(SCREEN_W - SPR_W);
  localparam logic signed [11:0] C_YMAX = 12'(SCREEN_H - SPR_H);

  state_t        r_state;
  logic          r_cond_q;
  logic          r_face_left;
  logic [FB-1:0] r_frame;
  logic [DB-1:0] r_div;
  logic [10:0]   r_x0, r_y0, r_x1, r_y1;
  logic [9:0]    r_sprite;

  logic                w_cond, w_tick;
  logic                w_go_l, w_go_r, w_go_u, w_go_d, w_any;
  logic signed [11:0]  w_x_sum, w_y_sum;
  logic [10:0]         w_x_new, w_y_new;
  logic [FB-1:0]       w_frame_nx;
  logic [DB-1:0]       w_div_nx;
  logic                w_face_nx;

  // ROM column of a frame: left-facing frames sit after the right-facing block
  function automatic logic [9:0] sprite_of(input logic [FB-1:0] f, input logic left);
    int v;
    v = int'(f) * SPR_W + (left ? NUM_FRAMES * SPR_W : 0);
    return v[9:0];
  endfunction

  // One tick per raster frame: the start of vertical blanking, edge-detected so long holds count once
  assign w_cond = (vc == 11'(SCREEN_H)) && (hc == 11'd0);
  assign w_tick = w_cond & ~r_cond_q;

  // Opposing buttons cancel their axis; all four together count as nothing pressed
  assign w_go_l = btn_l & ~btn_r;
  assign w_go_r = btn_r & ~btn_l;
  assign w_go_u = btn_u & ~btn_d;
  assign w_go_d = btn_d & ~btn_u;
  assign w_any  = (btn_l | btn_r | btn_u | btn_d) & ~(btn_l & btn_r & btn_u & btn_d);
  assign w_face_nx = w_go_l ? 1'b1 : (w_go_r ? 1'b0 : r_face_left);

  // Candidate position with signed headroom, then clamped to keep the sprite on screen
  always_comb begin
    w_x_sum = $signed({1'b0, r_x0});
    w_y_sum = $signed({1'b0, r_y0});
    if (w_go_l) w_x_sum = w_x_sum - C_STEP;
    if (w_go_r) w_x_sum = w_x_sum + C_STEP;
    if (w_go_u) w_y_sum = w_y_sum - C_STEP;
    if (w_go_d) w_y_sum = w_y_sum + C_STEP;
    if (w_x_sum < 12'sd0)       w_x_new = 11'd0;
    else if (w_x_sum > C_XMAX)  w_x_new = C_XMAX[10:0];
    else                        w_x_new = w_x_sum[10:0];
    if (w_y_sum < 12'sd0)       w_y_new = 11'd0;
    else if (w_y_sum > C_YMAX)  w_y_new = C_YMAX[10:0];
    else                        w_y_new = w_y_sum[10:0];
  end

  // Animation divider: the frame index advances once every FRAME_DIV walking ticks
  always_comb begin
    w_div_nx   = r_div;
    w_frame_nx = r_frame;
    if (r_div == DIV_LAST) begin
      w_div_nx   = '0;
      w_frame_nx = (r_frame == FRAME_LAST) ? '0 : r_frame + FB'(1);
    end else begin
      w_div_nx = r_div + DB'(1);
    end
  end

  // State machine and all registered outputs; nothing moves except on a frame tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cond_q    <= 1'b0;
      r_face_left <= 1'b0;
      r_frame     <= '0;
      r_div       <= '0;
      r_x0        <= 11'(START_X);
      r_y0        <= 11'(START_Y);
      r_x1        <= 11'(START_X + SPR_W);
      r_y1        <= 11'(START_Y + SPR_H);
      r_sprite    <= '0;
    end else begin
      r_cond_q <= w_cond;
      if (w_tick) begin
        if (pause) begin
          r_state <= PAUSE;
        end else if (w_any) begin
          r_state     <= WALK;
          r_x0        <= w_x_new;
          r_y0        <= w_y_new;
          r_x1        <= w_x_new + 11'(SPR_W);
          r_y1        <= w_y_new + 11'(SPR_H);
          r_div       <= w_div_nx;
          r_frame     <= w_frame_nx;
          r_face_left <= w_face_nx;
          r_sprite    <= sprite_of(w_frame_nx, w_face_nx);
        end else begin
          r_state  <= IDLE;
          r_div    <= '0;
          r_frame  <= '0;
          r_sprite <= sprite_of('0, r_face_left);
        end
      end
    end
  end

  assign x0         = r_x0;
  assign y0         = r_y0;
  assign x1         = r_x1;
  assign y1         = r_y1;
  assign sprite_num = r_sprite;
  assign state_o    = r_state;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// tb/tb_sprite_anim_ctrl.sv - scoreboard bench for sprite_anim_ctrl against a behavioural model
module tb_sprite_anim_ctrl;

  localparam int W = 60, H = 80, NF = 4, FD = 8, S = 2;
  localparam int SW = 640, SH = 480, SX = 290, SY = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hc = '0, vc = '0;
  logic        btn_l = 0, btn_r = 0, btn_u = 0, btn_d = 0, pause = 0;
  logic [10:0] x0, y0, x1, y1;
  logic [9:0]  sprite_num;
  logic [1:0]  state_o;

  sprite_anim_ctrl dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d), .pause(pause),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .sprite_num(sprite_num), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int spr;
    int st;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  bit   armed = 0;
  bit   tick_sent = 0;

  // reference model: position, facing, and count of walking ticks since last idle
  int mx, my, mleft, mwt, mst;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.x   = mx;
    e.y   = my;
    e.spr = ((mwt / FD) % NF) * W + (mleft ? NF * W : 0);
    e.st  = mst;
    return e;
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    mx = SX; my = SY; mleft = 0; mwt = 0; mst = 0;
  endtask

  task automatic model_tick(input bit l, r, u, d, p);
    int dx, dy;
    if (p) begin
      mst = 2;
    end else if ((l || r || u || d) && !(l && r && u && d)) begin
      dx = (l && !r) ? -S : ((r && !l) ? S : 0);
      dy = (u && !d) ? -S : ((d && !u) ? S : 0);
      mx = clampi(mx + dx, SW - W);
      my = clampi(my + dy, SH - H);
      if (l && !r) mleft = 1;
      else if (r && !l) mleft = 0;
      mwt++;
      mst = 1;
    end else begin
      mst = 0;
      mwt = 0;
    end
  endtask

  // monitor: adopts a new expectation after each issued tick, and checks outputs every cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        if (tick_sent) begin
          tick_sent = 0;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow at %0t", $time);
          end else begin
            cur = q.pop_front();
          end
        end
        chk("x0", int'(x0), cur.x);
        chk("y0", int'(y0), cur.y);
        chk("x1", int'(x1), cur.x + W);
        chk("y1", int'(y1), cur.y + H);
        chk("sprite_num", int'(sprite_num), cur.spr);
        chk("state_o", int'(state_o), cur.st);
      end
    end
  end

  // reset held two clks with a coincident tick condition and random pause
  task automatic do_reset();
    @(negedge clk);
    rst = 1; vc = 11'(SH); hc = '0; pause = 1'($urandom % 2); btn_r = 1;
    model_reset();
    q.push_back(model_out());
    tick_sent = 1;
    armed = 1;
    @(negedge clk);
    vc = '0;
    @(negedge clk);
    rst = 0; pause = 0; btn_r = 0;
  endtask

  // one raster frame: tick condition held four clks, optional input noise off-tick
  task automatic do_tick(input bit l, r, u, d, p, input bit noise);
    @(negedge clk);
    btn_l = l; btn_r = r; btn_u = u; btn_d = d; pause = p;
    vc = 11'(SH); hc = '0;
    model_tick(l, r, u, d, p);
    q.push_back(model_out());
    tick_sent = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (noise) begin
        btn_l = 1'($urandom % 2); btn_r = 1'($urandom % 2);
        btn_u = 1'($urandom % 2); btn_d = 1'($urandom % 2);
        pause = 1'($urandom % 2);
      end
    end
    @(negedge clk);
    if (noise && ($urandom % 2 == 1)) begin
      vc = 11'(SH); hc = 11'($urandom_range(1, 799));
    end else begin
      vc = 11'($urandom_range(0, SH - 1)); hc = 11'($urandom_range(0, 799));
    end
  endtask

  initial begin
    bit l, r, u, d, p;

    do_reset();
    chk("reset_x0", int'(x0), 290);
    chk("reset_y0", int'(y0), 200);
    chk("reset_x1", int'(x1), 350);
    chk("reset_y1", int'(y1), 280);
    chk("reset_state", int'(state_o), 0);

    for (int i = 0; i < 3; i++) do_tick(0, 1, 0, 0, 0, 0);
    chk("hold3_x0", int'(x0), 296);
    chk("hold3_state", int'(state_o), 1);

    do_reset();
    for (int i = 0; i < 8; i++) do_tick(0, 1, 0, 0, 0, 1);
    chk("anim8_sprite", int'(sprite_num), 60);
    for (int i = 0; i < 24; i++) do_tick(0, 1, 0, 0, 0, 1);
    chk("anim32_sprite", int'(sprite_num), 0);

    do_reset();
    for (int i = 0; i < 8; i++) do_tick(1, 0, 0, 0, 0, 0);
    chk("left8_sprite", int'(sprite_num), 300);
    chk("left8_x0", int'(x0), 274);

    do_reset();
    for (int i = 0; i < 150; i++) do_tick(1, 0, 1, 0, 0, 0);
    chk("clamp_x0", int'(x0), 0);
    chk("clamp_y0", int'(y0), 0);
    do_tick(1, 0, 1, 0, 0, 0);
    chk("clamp_hold_x0", int'(x0), 0);

    do_reset();
    for (int i = 0; i < 5; i++) do_tick(0, 1, 0, 0, 0, 0);
    do_tick(1, 1, 0, 0, 0, 0);
    chk("cancel_x0", int'(x0), 300);

    do_reset();
    for (int i = 0; i < 3; i++) do_tick(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) do_tick(0, 1, 0, 1, 1, 1);
    chk("pause_state", int'(state_o), 2);
    chk("pause_x0", int'(x0), 296);
    chk("pause_sprite", int'(sprite_num), 0);
    do_tick(0, 0, 0, 1, 0, 0);
    chk("resume_state", int'(state_o), 1);
    chk("resume_y0", int'(y0), 202);
    do_tick(0, 0, 0, 1, 0, 0);
    chk("resume_y0_2", int'(y0), 204);

    // mid-walk reset then randomized ticks
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        l = ($urandom_range(0, 2) == 0); r = ($urandom_range(0, 2) == 0);
        u = ($urandom_range(0, 2) == 0); d = ($urandom_range(0, 2) == 0);
        p = ($urandom_range(0, 9) == 0);
        do_tick(l, r, u, d, p, 1);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
